// File: rtl/beam_mask_pkg.sv
// Shared types and constants for the beam-mask scheduler.
//   NBEAMS_DEF : default total beam count
//   LO_W       : width of the low mask half written by mask_wr_i[0]
//   beam_mask_t, sched_state_t : mask payload and scheduler state types
package beam_mask_pkg;

    localparam int unsigned NBEAMS_DEF = 48;
    localparam int unsigned LO_W       = 18;

    typedef logic [NBEAMS_DEF-1:0] beam_mask_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        GENRST = 2'd2
    } sched_state_t;

endpackage

// File: rtl/beam_mask_timeout_ctr.sv
// Clear/enable up-counter that stops at TIMEOUT_CLKS-1 and flags it.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : synchronous clear (dominates en)
//   en         : count enable
//   tc_c       : terminal count reached (decoded from the count register)
module beam_mask_timeout_ctr #(
    parameter int unsigned TIMEOUT_CLKS = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc_c
);

    localparam int unsigned CW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CLKS - 1);

    logic [CW-1:0] cnt;

    // Holds at the terminal value so tc_c stays asserted until cleared.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !tc_c) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tc_c = (cnt == TERM);

endmodule

// File: rtl/beam_mask_scheduler.sv
// Schedules shadow -> active beam-mask transfers onto trigger frame boundaries.
// Ports:
//   ifclk, ifclk_rstn : clock, synchronous active-low reset
//   gen_rst_i         : generator reset level, forces all beams masked
//   mask_i, mask_wr_i : staged mask data and per-half shadow write strobes
//   mask_update_i     : request to transfer shadow to active
//   sync_i            : frame-boundary strobe
//   status_clr_i      : clears timeout flag and coalesce count
//   active_mask_o     : mask to beams (1 = masked)
//   pending_o         : high while a transfer is armed
//   applied_o         : pulse the cycle after the active mask was loaded
//   timeout_flag_o    : sticky, set by a timeout-forced transfer
//   coalesce_cnt_o    : saturating count of requests arriving while armed
module beam_mask_scheduler
    import beam_mask_pkg::*;
#(
    parameter int unsigned NBEAMS       = NBEAMS_DEF,
    parameter int unsigned TIMEOUT_CLKS = 1024,
    parameter int unsigned CNT_W        = 8
) (
    input  logic              ifclk,
    input  logic              ifclk_rstn,
    input  logic              gen_rst_i,
    input  logic [NBEAMS-1:0] mask_i,
    input  logic [1:0]        mask_wr_i,
    input  logic              mask_update_i,
    input  logic              sync_i,
    input  logic              status_clr_i,
    output logic [NBEAMS-1:0] active_mask_o,
    output logic              pending_o,
    output logic              applied_o,
    output logic              timeout_flag_o,
    output logic [CNT_W-1:0]  coalesce_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    sched_state_t      state_q;
    sched_state_t      state_d;
    logic              req_mem_q;
    logic              req_mem_d;
    logic              apply;
    logic              forced;
    logic              tc;
    logic [NBEAMS-1:0] shadow_q;
    logic [NBEAMS-1:0] shadow_d;
    logic [NBEAMS-1:0] active_q;
    logic              pending_q;
    logic              applied_q;
    logic              flag_q;
    logic [CNT_W-1:0]  coal_q;

    // Shadow next value; a write coincident with an apply is carried into it.
    always_comb begin
        shadow_d = shadow_q;
        if (mask_wr_i[0]) begin
            shadow_d[LO_W-1:0] = mask_i[LO_W-1:0];
        end
        if (mask_wr_i[1]) begin
            shadow_d[NBEAMS-1:LO_W] = mask_i[NBEAMS-1:LO_W];
        end
    end

    // Armed-time counter; restarts every time the FSM enters ARMED.
    beam_mask_timeout_ctr #(
        .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) u_timeout_ctr (
        .clk  (ifclk),
        .rst_n(ifclk_rstn),
        .clr  (state_q != ARMED),
        .en   (state_q == ARMED),
        .tc_c (tc)
    );

    // State register.
    always_ff @(posedge ifclk) begin
        if (!ifclk_rstn) begin
            state_q   <= IDLE;
            req_mem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_mem_q <= req_mem_d;
        end
    end

    // Next state and apply decision; generator reset overrides everything.
    always_comb begin
        state_d   = state_q;
        req_mem_d = 1'b0;
        apply     = 1'b0;
        forced    = 1'b0;
        if (gen_rst_i) begin
            state_d   = GENRST;
            req_mem_d = mask_update_i || (state_q == ARMED) ||
                        ((state_q == GENRST) && req_mem_q);
        end else begin
            case (state_q)
                IDLE: begin
                    if (mask_update_i) begin
                        state_d = ARMED;
                    end
                end
                ARMED: begin
                    if (sync_i) begin
                        apply   = 1'b1;
                        state_d = IDLE;
                    end else if (tc) begin
                        apply   = 1'b1;
                        forced  = 1'b1;
                        state_d = IDLE;
                    end
                end
                GENRST: begin
                    state_d = (req_mem_q || mask_update_i) ? ARMED : IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Mask registers and status.
    always_ff @(posedge ifclk) begin
        if (!ifclk_rstn) begin
            shadow_q  <= '1;
            active_q  <= '1;
            pending_q <= 1'b0;
            applied_q <= 1'b0;
            flag_q    <= 1'b0;
            coal_q    <= '0;
        end else begin
            shadow_q  <= shadow_d;
            pending_q <= (state_d == ARMED);
            applied_q <= apply;
            if (apply) begin
                active_q <= shadow_d;
            end
            if (forced) begin
                flag_q <= 1'b1;
            end else if (status_clr_i) begin
                flag_q <= 1'b0;
            end
            // An increment (even a saturated one) beats a clear.
            if ((state_q == ARMED) && mask_update_i) begin
                if (coal_q != CNT_MAX) begin
                    coal_q <= coal_q + CNT_W'(1);
                end
            end else if (status_clr_i) begin
                coal_q <= '0;
            end
        end
    end

    assign active_mask_o  = gen_rst_i ? '1 : active_q;
    assign pending_o      = pending_q;
    assign applied_o      = applied_q;
    assign timeout_flag_o = flag_q;
    assign coalesce_cnt_o = coal_q;

endmodule
